// File: rtl/axis_packet_rr_arbiter_pkg.sv
// Shared definitions for the packet round-robin arbiter:
// the input count and the two-state arbiter FSM encoding.
package axis_packet_rr_arbiter_pkg;
   localparam int NUM_INPUTS = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;
endpackage

// File: rtl/axis_packet_rr_arbiter_rr_priority_select.sv
// Combinational round-robin search: first set request after i_ptr.
// Ports: i_req (requests), i_ptr (last grant), o_index, o_found.
module rr_priority_select
   import axis_packet_rr_arbiter_pkg::*;
(
   input  logic [NUM_INPUTS-1:0] i_req,
   input  logic [1:0]            i_ptr,
   output logic [1:0]            o_index,
   output logic                  o_found
);
   logic [1:0] w_cand;

   // Walk from the lowest priority (ptr+4) up to ptr+1 so the
   // nearest requester after the pointer is written last and wins.
   always_comb begin
      o_index = 2'd0;
      o_found = 1'b0;
      w_cand  = 2'd0;
      for (int k = NUM_INPUTS; k >= 1; k--) begin
         w_cand = i_ptr + 2'(k);
         if (i_req[w_cand]) begin
            o_index = w_cand;
            o_found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// 4:1 AXI-Stream packet arbiter, whole-packet round-robin grants.
// Ports: axis_input_* (4 sliced streams), axis_arb_* (output
// stream), grant_valid/grant_index, pkt_count, overlength_err.
module axis_packet_rr_arbiter
   import axis_packet_rr_arbiter_pkg::*;
#(
   parameter int TDATA_WIDTH = 256,
   parameter int TUSER_WIDTH = 128,
   parameter int MAX_BEATS   = 1024
) (
   input  logic                                axis_aclk,
   input  logic                                axis_resetn,
   input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]   axis_input_tdata,
   input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0] axis_input_tkeep,
   input  logic [NUM_INPUTS*TUSER_WIDTH-1:0]   axis_input_tuser,
   input  logic [NUM_INPUTS-1:0]               axis_input_tvalid,
   output logic [NUM_INPUTS-1:0]               axis_input_tready,
   input  logic [NUM_INPUTS-1:0]               axis_input_tlast,
   output logic [TDATA_WIDTH-1:0]              axis_arb_tdata,
   output logic [TDATA_WIDTH/8-1:0]            axis_arb_tkeep,
   output logic [TUSER_WIDTH-1:0]              axis_arb_tuser,
   output logic                                axis_arb_tvalid,
   output logic                                axis_arb_tlast,
   input  logic                                axis_arb_tready,
   output logic                                grant_valid,
   output logic [1:0]                          grant_index,
   output logic [31:0]                         pkt_count,
   output logic                                overlength_err
);
   localparam int KW = TDATA_WIDTH / 8;
   localparam int CW = $clog2(MAX_BEATS + 1);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic [1:0]  r_grant_index;
   logic [1:0]  r_last_grant;
   logic [CW-1:0] r_beats;
   logic [31:0] r_pkt_count;
   logic        r_ovl;
   logic [1:0]  w_sel;
   logic        w_found;
   logic        w_busy;
   logic        w_hs;

   rr_priority_select u_sel (
      .i_req   (axis_input_tvalid),
      .i_ptr   (r_last_grant),
      .o_index (w_sel),
      .o_found (w_found)
   );

   assign w_busy = (r_state == BUSY);
   assign w_hs   = axis_arb_tvalid & axis_arb_tready;

   // Data sidebands pass through unconditionally; only valid and
   // ready are qualified by the grant.
   assign axis_arb_tdata = axis_input_tdata[
      int'(r_grant_index)*TDATA_WIDTH +: TDATA_WIDTH];
   assign axis_arb_tkeep = axis_input_tkeep[
      int'(r_grant_index)*KW +: KW];
   assign axis_arb_tuser = axis_input_tuser[
      int'(r_grant_index)*TUSER_WIDTH +: TUSER_WIDTH];
   assign axis_arb_tlast  = axis_input_tlast[r_grant_index];
   assign axis_arb_tvalid = w_busy &
      axis_input_tvalid[r_grant_index];

   always_comb begin
      axis_input_tready = '0;
      if (w_busy)
         axis_input_tready[r_grant_index] = axis_arb_tready;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_found) w_next = BUSY;
         BUSY:    if (w_hs && axis_arb_tlast) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) r_state <= IDLE;
      else              r_state <= w_next;
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         r_grant_index <= 2'd0;
         r_last_grant  <= 2'd3;
         r_beats       <= '0;
         r_pkt_count   <= '0;
         r_ovl         <= 1'b0;
      end else begin
         if (!w_busy && w_found)
            r_grant_index <= w_sel;
         if (w_hs) begin
            if (axis_arb_tlast) begin
               r_last_grant <= r_grant_index;
               r_pkt_count  <= r_pkt_count + 32'd1;
               r_beats      <= '0;
            end else begin
               // Beat MAX_BEATS is still non-last: packet too long.
               if (r_beats == CW'(MAX_BEATS - 1))
                  r_ovl <= 1'b1;
               if (r_beats != CW'(MAX_BEATS))
                  r_beats <= r_beats + 1'b1;
            end
         end
      end
   end

   assign grant_valid    = w_busy;
   assign grant_index    = r_grant_index;
   assign pkt_count      = r_pkt_count;
   assign overlength_err = r_ovl;
endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Self-checking bench for axis_packet_rr_arbiter: random packets
// scored per input against a packet-level round-robin model.
module tb_axis_packet_rr_arbiter;
   localparam int TDW = 32;
   localparam int TUW = 8;
   localparam int MB  = 8;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic [7:0]  u;
      logic        l;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_tdata;
   logic [15:0]  in_tkeep;
   logic [31:0]  in_tuser;
   logic [3:0]   in_tvalid;
   logic [3:0]   in_tready;
   logic [3:0]   in_tlast;
   logic [31:0]  arb_tdata;
   logic [3:0]   arb_tkeep;
   logic [7:0]   arb_tuser;
   logic         arb_tvalid;
   logic         arb_tlast;
   logic         arb_tready;
   logic         gvalid;
   logic [1:0]   gidx;
   logic [31:0]  pcnt;
   logic         ovl;

   axis_packet_rr_arbiter #(
      .TDATA_WIDTH (TDW),
      .TUSER_WIDTH (TUW),
      .MAX_BEATS   (MB)
   ) dut (
      .axis_aclk         (clk),
      .axis_resetn       (rst_n),
      .axis_input_tdata  (in_tdata),
      .axis_input_tkeep  (in_tkeep),
      .axis_input_tuser  (in_tuser),
      .axis_input_tvalid (in_tvalid),
      .axis_input_tready (in_tready),
      .axis_input_tlast  (in_tlast),
      .axis_arb_tdata    (arb_tdata),
      .axis_arb_tkeep    (arb_tkeep),
      .axis_arb_tuser    (arb_tuser),
      .axis_arb_tvalid   (arb_tvalid),
      .axis_arb_tlast    (arb_tlast),
      .axis_arb_tready   (arb_tready),
      .grant_valid       (gvalid),
      .grant_index       (gidx),
      .pkt_count         (pcnt),
      .overlength_err    (ovl)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   beat_t srcq[4][$];
   beat_t expq[4][$];
   int    out_src[$];
   int    start_dly[4];
   int    stall_beat[4];
   int    stall_rem[4];
   int    sent[4];
   int    pkt_id = 0;
   int    bubbles;
   int    hs_total;

   bit          m_busy;
   int          m_owner;
   int          m_last;
   logic [31:0] m_cnt;
   bit          m_ovl;
   int          m_beats;

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_last  = 3;
      m_cnt   = 0;
      m_ovl   = 0;
      m_beats = 0;
      for (int i = 0; i < 4; i++) begin
         srcq[i].delete();
         expq[i].delete();
      end
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 4; i++) begin
         start_dly[i]  = 0;
         stall_beat[i] = -1;
         stall_rem[i]  = 0;
         sent[i]       = 0;
      end
      out_src.delete();
   endtask

   task automatic add_pkt(input int i, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.d = {8'(i), 8'(pkt_id), 8'(k), 8'($urandom)};
         b.k = 4'($urandom);
         b.u = 8'($urandom);
         b.l = (k == n - 1);
         srcq[i].push_back(b);
         expq[i].push_back(b);
      end
      pkt_id++;
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy;
      for (int i = 0; i < 4; i++)
         if (srcq[i].size() > 0) p = 1;
      return p;
   endfunction

   task automatic run_engine(input int max_cyc, input int rdy_pct,
                             input int stop_hs);
      int cyc;
      beat_t b;
      logic [3:0] etr;
      logic etv;
      bit found;
      int c;
      cyc = 0;
      bubbles = 0;
      hs_total = 0;
      @(posedge clk); #1;
      while (pending()) begin
         if (cyc >= max_cyc) begin
            checks++; errors++;
            $display("FAIL timeout: cycles %0d limit %0d", cyc, max_cyc);
            break;
         end
         for (int i = 0; i < 4; i++) begin
            logic v;
            v = (srcq[i].size() > 0) && (cyc >= start_dly[i]);
            if (v && sent[i] == stall_beat[i] && stall_rem[i] > 0) begin
               v = 1'b0;
               stall_rem[i]--;
            end
            in_tvalid[i] = v;
            if (srcq[i].size() > 0) begin
               b = srcq[i][0];
               in_tdata[i*32 +: 32] = b.d;
               in_tkeep[i*4 +: 4]   = b.k;
               in_tuser[i*8 +: 8]   = b.u;
               in_tlast[i]          = b.l;
            end else begin
               in_tdata[i*32 +: 32] = '0;
               in_tkeep[i*4 +: 4]   = '0;
               in_tuser[i*8 +: 8]   = '0;
               in_tlast[i]          = 1'b0;
            end
         end
         arb_tready = ($urandom_range(99) < rdy_pct);
         #1;
         if (stop_hs >= 0 && hs_total == stop_hs) return;
         etv = m_busy ? in_tvalid[m_owner] : 1'b0;
         etr = (m_busy && arb_tready) ? (4'b0001 << m_owner) : 4'b0;
         checks++;
         if (gvalid !== m_busy) begin
            errors++;
            $display("FAIL grant_valid: got %b want %b", gvalid, m_busy);
         end
         checks++;
         if (arb_tvalid !== etv) begin
            errors++;
            $display("FAIL arb_tvalid: got %b want %b", arb_tvalid, etv);
         end
         checks++;
         if (in_tready !== etr) begin
            errors++;
            $display("FAIL tready: got %b want %b", in_tready, etr);
         end
         checks++;
         if (pcnt !== m_cnt) begin
            errors++;
            $display("FAIL pkt_count: got %0d want %0d", pcnt, m_cnt);
         end
         checks++;
         if (ovl !== m_ovl) begin
            errors++;
            $display("FAIL overlength: got %b want %b", ovl, m_ovl);
         end
         if (m_busy) begin
            checks++;
            if (gidx !== 2'(m_owner)) begin
               errors++;
               $display("FAIL grant_index: got %0d want %0d", gidx, m_owner);
            end
         end
         if (!gvalid && (|in_tvalid)) bubbles++;
         if (m_busy && etv && arb_tready) begin
            checks++;
            if (expq[m_owner].size() == 0) begin
               errors++;
               $display("FAIL scoreboard: got extra beat want none");
            end else begin
               b = expq[m_owner].pop_front();
               if (arb_tdata !== b.d || arb_tkeep !== b.k ||
                   arb_tuser !== b.u || arb_tlast !== b.l) begin
                  errors++;
                  $display("FAIL beat: got %h/%h/%h/%b want %h/%h/%h/%b",
                     arb_tdata, arb_tkeep, arb_tuser, arb_tlast,
                     b.d, b.k, b.u, b.l);
               end
               hs_total++;
               if (!b.l && m_beats == MB - 1) m_ovl = 1;
               if (b.l) begin
                  out_src.push_back(int'(arb_tdata[31:24]));
                  m_busy  = 0;
                  m_last  = m_owner;
                  m_cnt   = m_cnt + 32'd1;
                  m_beats = 0;
               end else if (m_beats < MB) begin
                  m_beats++;
               end
            end
         end else if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               c = (m_last + k) % 4;
               if (!found && in_tvalid[c]) begin
                  found   = 1;
                  m_busy  = 1;
                  m_owner = c;
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (in_tvalid[i] && in_tready[i]) begin
               void'(srcq[i].pop_front());
               sent[i]++;
            end
         cyc++;
         @(posedge clk); #1;
      end
      in_tvalid = '0;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (in_tready !== 4'b0 || arb_tvalid !== 1'b0 ||
          gvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s handshake: got %b/%b/%b want 0/0/0",
            tag, in_tready, arb_tvalid, gvalid);
      end
      checks++;
      if (gidx !== 2'd0 || pcnt !== 32'd0 || ovl !== 1'b0) begin
         errors++;
         $display("FAIL %s regs: got %0d/%0d/%b want 0/0/0",
            tag, gidx, pcnt, ovl);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_tdata = '0; in_tkeep = '0; in_tuser = '0;
      in_tvalid = '0; in_tlast = '0; arb_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      in_tvalid = 4'hF;
      #1;
      check_idle_outputs("reset_valid");
      in_tvalid = '0;
      rst_n = 1'b1;
      model_reset();
      clear_stim();
   endtask

   task automatic test_all_four();
      clear_stim();
      for (int i = 0; i < 4; i++) add_pkt(i, 3);
      run_engine(200, 100, -1);
      checks++;
      if (out_src.size() != 4) begin
         errors++;
         $display("FAIL four_count: got %0d want 4", out_src.size());
      end else
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_src[i] != i) begin
               errors++;
               $display("FAIL four_order[%0d]: got %0d want %0d",
                  i, out_src[i], i);
            end
         end
      checks++;
      if (pcnt !== 32'd4) begin
         errors++;
         $display("FAIL four_pkt_count: got %0d want 4", pcnt);
      end
      checks++;
      if (bubbles != 4) begin
         errors++;
         $display("FAIL four_bubbles: got %0d want 4", bubbles);
      end
   endtask

   task automatic test_single_requester();
      clear_stim();
      for (int p = 0; p < 5; p++) add_pkt(2, 1);
      run_engine(100, 100, -1);
      checks++;
      if (out_src.size() != 5) begin
         errors++;
         $display("FAIL single_count: got %0d want 5", out_src.size());
      end
      foreach (out_src[p]) begin
         checks++;
         if (out_src[p] != 2) begin
            errors++;
            $display("FAIL single_src[%0d]: got %0d want 2", p, out_src[p]);
         end
      end
      checks++;
      if (bubbles != 5) begin
         errors++;
         $display("FAIL single_bubbles: got %0d want 5", bubbles);
      end
   endtask

   task automatic test_stall();
      clear_stim();
      add_pkt(1, 4);
      add_pkt(3, 2);
      start_dly[3]  = 1;
      stall_beat[1] = 2;
      stall_rem[1]  = 3;
      run_engine(100, 100, -1);
      checks++;
      if (out_src.size() != 2 || out_src[0] != 1 || out_src[1] != 3) begin
         errors++;
         $display("FAIL stall_order: got size %0d want 1,3", out_src.size());
      end
   endtask

   task automatic test_saturation();
      int cnt[4];
      int mx, mn;
      clear_stim();
      for (int p = 0; p < 250; p++)
         for (int i = 0; i < 4; i++)
            add_pkt(i, int'($urandom_range(6, 1)));
      run_engine(40000, 50, -1);
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      foreach (out_src[p]) begin
         if (out_src[p] >= 0 && out_src[p] < 4) cnt[out_src[p]]++;
         if (p > 0) begin
            checks++;
            if (out_src[p] != (out_src[p-1] + 1) % 4) begin
               errors++;
               $display("FAIL sat_rr[%0d]: got %0d want %0d", p,
                  out_src[p], (out_src[p-1] + 1) % 4);
            end
         end
      end
      mx = cnt[0]; mn = cnt[0];
      for (int i = 0; i < 4; i++) begin
         if (cnt[i] > mx) mx = cnt[i];
         if (cnt[i] < mn) mn = cnt[i];
         checks++;
         if (expq[i].size() != 0) begin
            errors++;
            $display("FAIL sat_loss[%0d]: got %0d left want 0",
               i, expq[i].size());
         end
      end
      checks++;
      if (mx - mn > 1 || out_src.size() != 1000) begin
         errors++;
         $display("FAIL sat_fair: got spread %0d total %0d want <=1 1000",
            mx - mn, out_src.size());
      end
   endtask

   task automatic test_reset_midpkt();
      clear_stim();
      add_pkt(0, 2);
      run_engine(50, 100, -1);
      clear_stim();
      add_pkt(2, 4);
      run_engine(50, 100, 1);
      checks++;
      if (arb_tvalid !== 1'b1 || arb_tdata[31:24] !== 8'd2) begin
         errors++;
         $display("FAIL midpkt_pre: got %b/%0d want 1/2",
            arb_tvalid, arb_tdata[31:24]);
      end
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midpkt_reset");
      in_tvalid = '0;
      model_reset();
      clear_stim();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) add_pkt(i, 2);
      run_engine(100, 100, -1);
      checks++;
      if (out_src.size() != 4 || out_src[0] != 0) begin
         errors++;
         $display("FAIL midpkt_first: got size %0d want winner 0",
            out_src.size());
      end
   endtask

   task automatic test_overlength();
      clear_stim();
      add_pkt(1, MB);
      run_engine(100, 100, -1);
      checks++;
      if (ovl !== 1'b0) begin
         errors++;
         $display("FAIL ovl_boundary: got %b want 0", ovl);
      end
      clear_stim();
      add_pkt(1, MB + 1);
      run_engine(100, 70, -1);
      checks++;
      if (hs_total != MB + 1) begin
         errors++;
         $display("FAIL ovl_beats: got %0d want %0d", hs_total, MB + 1);
      end
      checks++;
      if (ovl !== 1'b1) begin
         errors++;
         $display("FAIL ovl_set: got %b want 1", ovl);
      end
      clear_stim();
      add_pkt(0, 2);
      run_engine(100, 100, -1);
      checks++;
      if (ovl !== 1'b1) begin
         errors++;
         $display("FAIL ovl_sticky: got %b want 1", ovl);
      end
   endtask

   initial begin
      test_reset();
      test_all_four();
      test_single_requester();
      test_stall();
      test_saturation();
      test_reset_midpkt();
      test_overlength();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_packet_rr_arbiter.md
AXIS_PACKET_RR_ARBITER -- requirements
Module: axis_packet_rr_arbiter

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 256: tdata width per stream; must be a multiple of 8.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128: tuser width per stream.
REQ-003 SHALL have parameter MAX_BEATS, default 1024: beat limit per packet, used only for the overlength flag.
REQ-004 SHALL have port axis_aclk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port axis_resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port axis_input_tdata, input, 4*TDATA_WIDTH: input i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH].
REQ-007 SHALL have port axis_input_tkeep, input, 4*TDATA_WIDTH/8: per-input tkeep, sliced the same way.
REQ-008 SHALL have port axis_input_tuser, input, 4*TUSER_WIDTH: per-input tuser, sliced the same way.
REQ-009 SHALL have port axis_input_tvalid, input, 4: per-input valid.
REQ-010 SHALL have port axis_input_tready, output, 4: per-input ready.
REQ-011 SHALL have port axis_input_tlast, input, 4: per-input last.
REQ-012 SHALL have ports axis_arb_tdata, tkeep, tuser, tvalid, tlast (outputs) and axis_arb_tready (input): the arbitrated stream.
REQ-013 SHALL have port grant_valid, output, 1: high while a packet is granted.
REQ-014 SHALL have port grant_index, output, 2: the granted input.
REQ-015 SHALL have port pkt_count, output, 32: packets forwarded, wraps modulo 2^32.
REQ-016 SHALL have port overlength_err, output, 1: sticky flag for a packet exceeding MAX_BEATS.

Function
REQ-017 SHALL arbitrate whole packets; a grant is held from the first beat through the tlast handshake, and beats of different inputs never interleave.
REQ-018 SHALL implement an FSM with states IDLE and BUSY.
REQ-019 IDLE: all axis_input_tready=0, axis_arb_tvalid=0, grant_valid=0.
REQ-020 IDLE, any axis_input_tvalid high: grant the first valid input searching last_grant+1, +2, +3, +4 (mod 4); register it in grant_index and enter BUSY next cycle.
REQ-021 IDLE, no tvalid: remain IDLE.
REQ-022 BUSY: the output is a combinational pass-through of input grant_index: arb tdata, tkeep, tuser, tlast and tvalid follow that input, and axis_input_tready[grant_index]=axis_arb_tready.
REQ-023 BUSY: tready of non-granted inputs=0.
REQ-024 BUSY, handshake (arb tvalid & tready) with tlast=1: last_grant<=grant_index, pkt_count+=1, beat counter<=0, next state IDLE.
REQ-025 BUSY, handshake with tlast=0: beat counter+=1, saturating at MAX_BEATS.
REQ-026 BUSY, granted tvalid low mid-packet: remain BUSY, no counter change, and no other input is served.
REQ-027 A handshake while the beat counter equals MAX_BEATS-1 with tlast=0 SHALL set overlength_err, which stays set until reset; forwarding is unaffected.
REQ-028 Arbitration latency: one bubble cycle (IDLE) between every packet; a single-beat packet occupies two cycles minimum.
REQ-029 Back-to-back requests from the same sole requester SHALL be re-granted after the IDLE cycle.
REQ-030 The beat counter width SHALL be clog2(MAX_BEATS+1).
REQ-031 The tkeep=0 beats SHALL be forwarded unmodified; no beat is dropped or created.

Reset
REQ-032 On axis_resetn=0, immediately: state=IDLE, last_grant=3 (input 0 highest priority first), grant_index=0, beat counter=0, pkt_count=0, overlength_err=0; all tready and arb tvalid=0.
REQ-033 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from IDLE with no memory of it.
REQ-034 Release of reset SHALL be synchronised to axis_aclk by the surrounding reset logic; the block samples it synchronously on deassertion.

Structure
REQ-035 SHALL place the state encoding (IDLE=0, BUSY=1) and NUM_INPUTS=4 in the shared AXIS utility package.
REQ-036 SHALL implement the round-robin first-requester search as one sub-module, rr_priority_select (4 requests plus 2-bit pointer in; 2-bit index plus found out), purely combinational.
REQ-037 SHALL have no FIFOs; buffering belongs to upstream/downstream blocks.

Verification
REQ-038 Inputs 0-3 each present one 3-beat packet simultaneously, arb tready=1 -> output order 0,1,2,3; each packet contiguous; pkt_count=4; 4 bubble cycles.
REQ-039 Only input 2 sends 5 single-beat packets -> all 5 forwarded, grant_index=2 each time, grant_valid toggles 1/0.
REQ-040 Input 1 is granted and drops tvalid for 3 cycles mid-packet while input 3 is valid -> input 3 tready stays 0 until input 1's tlast handshake, then input 3 is granted.
REQ-041 arb tready is random 50% during 4-input saturation for 1000 packets -> no data loss or reordering per input, and per-input grant counts differ by at most 1.
REQ-042 MAX_BEATS=8 and an 9-beat packet -> overlength_err rises on beat 8's handshake, all 9 beats forwarded, flag held after.
REQ-043 axis_resetn is asserted at beat 2 of a 4-beat packet -> outputs go to reset values in the same cycle; after release, input 0 wins if all inputs are valid.
